// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - round-robin shared ALU sequencer with a tagged response port
//
// Purpose: arbitrates two valid/ready requesters onto one ALU. A granted op is
// latched in IDLE, evaluated in EXEC, and its result is held in RESP until accepted.
// FSM: IDLE -> EXEC -> RESP -> IDLE.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_ctrl requester N operands and op code
//   rsp_valid/ready           response handshake
//   rsp_id                    requester that owns the response
//   rsp_data, rsp_zero/ovf/cout  ALU result and flags
//   stat_cnt0/1               saturating grant counters
// Optional feature: ALU_RR_STATS_EN builds the grant counters; otherwise they read 0.

module alu_rr_alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             cout
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;

    always_comb begin
        result = sum[WIDTH-1:0];
        ovf    = 1'b0;
        cout   = 1'b0;
        case (ctrl)
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0110: begin
                result = diff;
                // Operands of differing sign whose difference flips away from a.
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: result = ~(a | b);
            4'b1111: result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: begin
                // 0010 and every unassigned code execute as ADD.
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
        zero = (result == '0);
    end
endmodule

module alu_rr_sequencer #(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [3:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_zero,
    output logic              rsp_ovf,
    output logic              rsp_cout,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [3:0]       op_ctrl_q, op_ctrl_d;
    logic             op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic             grant0, grant1;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero, alu_ovf, alu_cout;

    // On a tie the requester that did not win last time is granted.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == S_IDLE) && grant0;
    assign req1_ready = (state_q == S_IDLE) && grant1;

    alu_rr_alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl   (op_ctrl_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .result (alu_result),
        .zero   (alu_zero),
        .ovf    (alu_ovf),
        .cout   (alu_cout)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_cout_d   = rsp_cout_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    op_a_d       = grant1 ? req1_a    : req0_a;
                    op_b_d       = grant1 ? req1_b    : req0_b;
                    op_ctrl_d    = grant1 ? req1_ctrl : req0_ctrl;
                    op_id_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = alu_result;
                rsp_zero_d  = alu_zero;
                rsp_ovf_d   = alu_ovf;
                rsp_cout_d  = alu_cout;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                // Data and flags are left as-is after acceptance.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ALU_RR_STATS_EN
    logic [STAT_W-1:0] stat_cnt0_q, stat_cnt0_d, stat_cnt1_q, stat_cnt1_d;

    always_comb begin
        stat_cnt0_d = stat_cnt0_q;
        stat_cnt1_d = stat_cnt1_q;
        if (req0_valid && req0_ready && (stat_cnt0_q != '1)) stat_cnt0_d = stat_cnt0_q + 1'b1;
        if (req1_valid && req1_ready && (stat_cnt1_q != '1)) stat_cnt1_d = stat_cnt1_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt0_q <= '0;
            stat_cnt1_q <= '0;
        end else begin
            stat_cnt0_q <= stat_cnt0_d;
            stat_cnt1_q <= stat_cnt1_d;
        end
    end

    assign stat_cnt0 = stat_cnt0_q;
    assign stat_cnt1 = stat_cnt1_q;
`else
    assign stat_cnt0 = '0;
    assign stat_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - self-checking bench for alu_rr_sequencer

module tb_alu_rr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_cout;
    logic [31:0] rsp_data;
    logic [1:0]  stat_cnt0, stat_cnt1;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.WIDTH(32), .STAT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout),
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        cout;
    } rsp_t;

    rsp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_EQ = 4'b1111;

    function automatic rsp_t model(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        rsp_t        r;
        longint      sa, sb, ss;
        logic [63:0] us;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.id = id; r.ovf = 1'b0; r.cout = 1'b0;
        case (c)
            OP_AND: r.data = a & b;
            OP_OR:  r.data = a | b;
            OP_SUB: begin
                ss = sa - sb;
                r.data = a - b;
                r.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_SLT: r.data = (sa < sb) ? 32'd1 : 32'd0;
            OP_NOR: r.data = ~(a | b);
            OP_EQ:  r.data = (a == b) ? 32'd1 : 32'd0;
            default: begin
                us = {32'd0, a} + {32'd0, b};
                ss = sa + sb;
                r.data = us[31:0];
                r.cout = us[32];
                r.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
        endcase
        r.zero = (r.data == 32'd0);
        return r;
    endfunction

    function automatic rsp_t observed();
        return {rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_cout};
    endfunction

    task automatic drive(input logic id, input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (id) begin req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; end
        else begin req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
    endtask

    // Leaves the bench at negedge+1 after the handshake edge.
    task automatic issue(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output bit granted);
        @(negedge clk);
        drive(id, 1'b1, c, a, b);
        granted = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin granted = 1; break; end
            @(negedge clk);
        end
        if (granted) exp_q.push_back(model(id, c, a, b));
        @(negedge clk);
        drive(id, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
    endtask

    task automatic wait_rsp(output bit got);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin got = 1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rsp_ready = 1'b0;
        do_reset();
        total_cnt++;
        if ({rsp_valid, observed()} !== '0) $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, observed()});
        else pass_cnt++;
        total_cnt++;
        if ({req0_ready, req1_ready, stat_cnt0, stat_cnt1} !== 6'd0)
            $display("FAIL reset_ready_stat: got %b expected 000000", {req0_ready, req1_ready, stat_cnt0, stat_cnt1});
        else pass_cnt++;
    endtask

    task automatic test_add_ovf();
        bit   ok;
        rsp_t e;
        rsp_ready = 1'b1;
        issue(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, ok);
        total_cnt++;
        if (!ok) $display("FAIL add_ovf_grant: got no req0_ready expected grant");
        else pass_cnt++;
        total_cnt++;
        if ({req0_ready, rsp_valid} !== 2'b00) $display("FAIL add_ovf_exec: got ready,valid=%b expected 00", {req0_ready, rsp_valid});
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if (!rsp_valid || exp_q.size() == 0) $display("FAIL add_ovf_latency: got rsp_valid=%b expected 1", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL add_ovf_rsp: got %h expected %h", observed(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_req1_seq();
        bit   ok, got;
        rsp_t e;
        rsp_ready = 1'b1;
        issue(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, ok);
        wait_rsp(got);
        total_cnt++;
        if (!ok || !got || exp_q.size() == 0) $display("FAIL req1_add_timeout: got ok=%0d got=%0d expected 1 1", ok, got);
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL req1_add_rsp: got %h expected %h", observed(), e);
            else pass_cnt++;
        end
        issue(1'b1, OP_SUB, 32'd5, 32'd5, ok);
        wait_rsp(got);
        total_cnt++;
        if (!ok || !got || exp_q.size() == 0) $display("FAIL req1_sub_timeout: got ok=%0d got=%0d expected 1 1", ok, got);
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL req1_sub_rsp: got %h expected %h", observed(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int   gcnt = 0, rcnt = 0, last_g = 0;
        rsp_t e;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(model(1'b0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00));
            exp_q.push_back(model(1'b1, OP_SLT, 32'h8000_0000, 32'h0000_0001));
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        drive(1'b1, 1'b1, OP_SLT, 32'h8000_0000, 32'h0000_0001);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                total_cnt++;
                if ({req0_ready, req1_ready} !== (gcnt[0] ? 2'b01 : 2'b10))
                    $display("FAIL b2b_grant_order: got %b expected %b", {req0_ready, req1_ready}, gcnt[0] ? 2'b01 : 2'b10);
                else pass_cnt++;
                if (gcnt > 0) begin
                    total_cnt++;
                    if (cyc - last_g != 3) $display("FAIL b2b_grant_spacing: got %0d expected 3", cyc - last_g);
                    else pass_cnt++;
                end
                last_g = cyc;
                gcnt++;
            end
            if (rsp_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (observed() !== e) $display("FAIL b2b_rsp%0d: got %h expected %h", rcnt, observed(), e);
                else pass_cnt++;
                rcnt++;
            end
            if (rcnt == 4) break;
            @(negedge clk);
            if (gcnt >= 4) begin
                drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
                drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
            end
        end
        total_cnt++;
        if (rcnt != 4 || gcnt != 4) $display("FAIL b2b_count: got grants=%0d rsps=%0d expected 4 4", gcnt, rcnt);
        else pass_cnt++;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_backpressure();
        bit   got;
        rsp_t e;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, OP_NOR, 32'd0, 32'd0);
        drive(1'b1, 1'b1, OP_EQ, 32'd7, 32'd7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL bp_first_grant: got %b expected 10", {req0_ready, req1_ready});
        else pass_cnt++;
        exp_q.push_back(model(1'b0, OP_NOR, 32'd0, 32'd0));
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({rsp_valid, req0_ready, req1_ready, observed()} !== {3'b100, exp_q[0]})
                $display("FAIL bp_hold%0d: got %h expected %h", i, {rsp_valid, req0_ready, req1_ready, observed()}, {3'b100, exp_q[0]});
            else pass_cnt++;
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        total_cnt++;
        if ({rsp_valid, observed()} !== {1'b1, e}) $display("FAIL bp_release: got %h expected %h", {rsp_valid, observed()}, {1'b1, e});
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b001)
            $display("FAIL bp_next_grant: got %b expected 001", {rsp_valid, req0_ready, req1_ready});
        else pass_cnt++;
        exp_q.push_back(model(1'b1, OP_EQ, 32'd7, 32'd7));
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        wait_rsp(got);
        total_cnt++;
        if (!got || exp_q.size() == 0) $display("FAIL bp_second_timeout: got no rsp expected rsp_valid");
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL bp_second_rsp: got %h expected %h", observed(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        bit   got;
        rsp_t e;
        int   stray = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, OP_OR, 32'h1234_0000, 32'h0000_5678);
        #1;
        total_cnt++;
        if (req1_ready !== 1'b1) $display("FAIL rmid_grant: got %b expected 1", req1_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk); #1;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", rsp_valid);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, OP_SUB, 32'd3, 32'd10);
        drive(1'b1, 1'b1, OP_AND, 32'hFFFF_FFFF, 32'h1);
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rmid_tie: got %b expected 10", {req0_ready, req1_ready});
        else pass_cnt++;
        exp_q.push_back(model(1'b0, OP_SUB, 32'd3, 32'd10));
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        wait_rsp(got);
        total_cnt++;
        if (!got || exp_q.size() == 0) $display("FAIL rmid_timeout: got no rsp expected rsp_valid");
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL rmid_rsp: got %h expected %h", observed(), e);
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) stray++;
        end
        total_cnt++;
        if (stray != 0) $display("FAIL rmid_stray_rsp: got %0d responses expected 0", stray);
        else pass_cnt++;
    endtask

    task automatic test_stats();
        bit          ok, got;
        rsp_t        e;
        logic [1:0]  exp0;
        logic [3:0]  ops[5] = '{OP_ADD, OP_SLT, OP_EQ, 4'b0101, OP_OR};
        rsp_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, ops[i], 32'h0000_0010 * i, 32'hFFFF_FFF0 + i, ok);
            wait_rsp(got);
            total_cnt++;
            if (!ok || !got || exp_q.size() == 0) $display("FAIL stats_op%0d_timeout: got ok=%0d got=%0d expected 1 1", i, ok, got);
            else begin
                e = exp_q.pop_front();
                if (observed() !== e) $display("FAIL stats_op%0d_rsp: got %h expected %h", i, observed(), e);
                else pass_cnt++;
            end
        end
`ifdef ALU_RR_STATS_EN
        exp0 = 2'd3;
`else
        exp0 = 2'd0;
`endif
        total_cnt++;
        if ({stat_cnt0, stat_cnt1} !== {exp0, 2'd0})
            $display("FAIL stats_cnt: got %0d,%0d expected %0d,0", stat_cnt0, stat_cnt1, exp0);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        test_reset();
        test_add_ovf();
        test_req1_seq();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
